fir_decim_fifo: RTL and testbench
=================================

// Module: fir_decim_fifo
// PURPOSE
//  Downstream stage of the 31-tap FIR. Captures each filtered sample (fir_d) once the FIR reports valid,
//  decimates by DEC (keeps 1 of every DEC samples) and buffers the kept samples in a small FIFO.
//  Samples leave through a valid/ready handshake to the output consumer (DAC/UART serializer).
//  An overflow is flagged, never silently hidden.
// PARAMETERS
//  DW     16  sample width; matches fir_d
//  DEC    4   decimation factor, >=1; DEC=1 passes every sample
//  DEPTH  8   FIFO entries, power of 2, >=2
//  AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk         in   1     system clock, rising edge
//  rst         in   1     asynchronous, active-low reset (0 = reset)
//  smp_strobe  in   1     one-cycle pulse per input sample; same signal that drives FIR data_valid
//  fir_valid   in   1     FIR output valid (level; high after pipeline warm-up)
//  fir_d       in   DW    FIR output sample, signed; updates the cycle after smp_strobe
//  out_valid   out  1     FIFO head holds a sample
//  out_data    out  DW    FIFO head sample, signed
//  out_ready   in   1     consumer accepts head this cycle
//  fifo_level  out  AW+1  entries stored, 0..DEPTH
//  ovf         out  1     sticky overflow flag
//  ovf_clr     in   1     one-cycle clear of ovf
// BEHAVIOUR
//  Reset (rst=0, any time, async): out_valid=0, out_data=0, fifo_level=0, ovf=0, phase counter=0,
//   capture register cleared; in-flight capture discarded; pointers to 0.
//  Capture: cap_en <= smp_strobe & fir_valid (registered). At the edge where cap_en=1, fir_d is sampled.
//   Capture therefore occurs one cycle after smp_strobe.
//  Decimation: phase counter 0..DEC-1 advances on every capture and wraps DEC-1 -> 0.
//   A captured sample is pushed only when phase==0. The counter is held at 0 while fir_valid=0,
//   so the first valid sample is always kept.
//  FIFO: first-word-fall-through. out_valid = (level!=0); out_data = mem[rd_ptr].
//   Pop when out_valid & out_ready. out_ready with out_valid=0 has no effect.
//  Latency: smp_strobe at cycle T -> kept sample written at edge T+1 -> out_valid=1, out_data valid in T+2.
//  Pointers: wr_ptr/rd_ptr wrap modulo DEPTH. level +1 on push only, -1 on pop only, unchanged on both.
//  Full (level=DEPTH):
//   - push with pop in same cycle: both performed, level stays DEPTH.
//   - push without pop: sample dropped, memory and pointers untouched, ovf<=1.
//  Empty: a push and out_ready in the same cycle does not pop; the sample appears next cycle.
//  ovf: set by a dropped push; cleared by ovf_clr. Set wins when both occur in the same cycle.
//  Arithmetic: no scaling or rounding; samples are stored bit-exact. Only the counters carry arithmetic.
// STRUCTURE
//  Shared package fir_pkg: FIR_DW=16, default DEC/DEPTH constants, signed sample type (sample_t).
//  Sub-module sync_fifo (DW, DEPTH): mem, pointers, level, full/empty, FWFT head.
//  Top level holds the capture register, the phase counter and the ovf logic.
// TESTING
//  1 DEC=4, fir_valid=1, 8 strobes with fir_d=1..8 -> FIFO receives 1,5; out_data=1 two cycles after
//    1st strobe; level=2.
//  2 fir_valid=0 for 3 strobes, then 1 -> first pushed sample is the first valid fir_d; level 0 until then.
//  3 DEC=1, out_ready=0, 9 strobes -> level=8, 9th dropped, ovf=1; ovf_clr pulse -> ovf=0.
//  4 Full, out_ready=1 same cycle as push -> level stays 8, head advances, ovf stays 0.
//  5 Negative samples 0x8000, 0xFFFF pushed -> read back bit-exact in order.
//  6 rst=0 asserted mid-stream with level=5 -> out_valid=0, level=0, ovf=0 immediately;
//    after release the first kept sample is the next capture.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and types for the FIR output path.
//   FIR_DW    : width of a filtered sample (fir_d)
//   DEF_DEC   : default decimation factor of the output stage
//   DEF_DEPTH : default output FIFO depth
//   sample_t  : signed filtered sample
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DW    = 16;
    localparam int DEF_DEC   = 4;
    localparam int DEF_DEPTH = 8;

    typedef logic signed [FIR_DW-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through FIFO. The head sample is visible on out_data while
// out_valid is high. A pop happens when out_valid & rd_ready.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   push       in   write request for wdata
//   wdata      in   signed sample to store
//   rd_ready   in   consumer accepts the head this cycle
//   out_valid  out  FIFO holds at least one sample
//   out_data   out  head sample (0 while empty)
//   level      out  number of stored samples, 0..DEPTH
//   full       out  level == DEPTH
//   drop       out  push refused because the FIFO is full and not popping
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic signed [DW-1:0]   wdata,
    input  logic                   rd_ready,
    output logic                   out_valid,
    output logic signed [DW-1:0]   out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic signed [DW-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 pop;
    logic                 wr_en;

    assign out_valid = (level != '0);
    assign full      = (level == FULL_LVL);
    assign pop       = out_valid & rd_ready;
    // When full, a write is only legal if the head leaves in the same cycle;
    // wr_ptr == rd_ptr then, and the old head is read before it is replaced.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    // Gated so the output reads 0 after reset even though mem is not cleared.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fir_decim_fifo.sv
// -----------------------------------------------------------------------------
// fir_decim_fifo
// Output stage of the 31-tap FIR: captures each valid filtered sample, keeps
// one of every DEC samples and buffers the kept samples in a FWFT FIFO that
// drains through a valid/ready handshake. Dropped samples set a sticky ovf.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset (0 = reset)
//   smp_strobe  in   one-cycle pulse per input sample
//   fir_valid   in   FIR output valid level
//   fir_d       in   signed FIR output, valid the cycle after smp_strobe
//   out_valid   out  FIFO head holds a sample
//   out_data    out  signed FIFO head sample
//   out_ready   in   consumer accepts the head this cycle
//   fifo_level  out  stored entries, 0..DEPTH
//   ovf         out  sticky overflow flag
//   ovf_clr     in   one-cycle clear of ovf (a simultaneous overflow wins)
// -----------------------------------------------------------------------------
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int DEC   = DEF_DEC,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   smp_strobe,
    input  logic                   fir_valid,
    input  logic signed [DW-1:0]   fir_d,
    output logic                   out_valid,
    output logic signed [DW-1:0]   out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;

    logic          vld_p0;
    logic [PW-1:0] phase_p0;
    logic          push_p0;
    logic          drop;
    logic          full_unused;

    function automatic logic [PW-1:0] phase_next(input logic [PW-1:0] ph);
        return (ph == PW'(DEC - 1)) ? '0 : ph + 1'b1;
    endfunction

    // Stage p0: capture enable, registered so it lines up with fir_d, which
    // settles one cycle after the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p0 <= 1'b0;
        else      vld_p0 <= smp_strobe & fir_valid;
    end

    // Decimation phase; forced to 0 while the FIR is warming up so the first
    // valid sample is always kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            phase_p0 <= '0;
        else if (!fir_valid) phase_p0 <= '0;
        else if (vld_p0)     phase_p0 <= phase_next(phase_p0);
    end

    assign push_p0 = vld_p0 & (phase_p0 == '0);

    // Stage p1: fir_d is written straight into the FIFO at the capture edge.
    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_p0),
        .wdata     (fir_d),
        .rd_ready  (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (fifo_level),
        .full      (full_unused),
        .drop      (drop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fir_decim_fifo.sv
module tb_fir_decim_fifo;

    logic               clk = 1'b0;
    logic               rst;
    logic               smp_strobe;
    logic               fir_valid;
    logic signed [15:0] fir_d;
    logic               out_ready;
    logic               ovf_clr;

    // DEC=4 instance
    logic               a_valid;
    logic signed [15:0] a_data;
    logic [3:0]         a_level;
    logic               a_ovf;
    // DEC=1 instance
    logic               b_valid;
    logic signed [15:0] b_data;
    logic [3:0]         b_level;
    logic               b_ovf;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    fir_decim_fifo #(.DW(16), .DEC(4), .DEPTH(8)) dut4 (
        .clk(clk), .rst(rst), .smp_strobe(smp_strobe), .fir_valid(fir_valid),
        .fir_d(fir_d), .out_valid(a_valid), .out_data(a_data), .out_ready(out_ready),
        .fifo_level(a_level), .ovf(a_ovf), .ovf_clr(ovf_clr)
    );

    fir_decim_fifo #(.DW(16), .DEC(1), .DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .smp_strobe(smp_strobe), .fir_valid(fir_valid),
        .fir_d(fir_d), .out_valid(b_valid), .out_data(b_data), .out_ready(out_ready),
        .fifo_level(b_level), .ovf(b_ovf), .ovf_clr(ovf_clr)
    );

    // Strobe in cycle T, fir_d presented in T+1 (optionally with out_ready /
    // ovf_clr in that capture cycle); returns #1 into cycle T+2.
    task automatic strobe(input logic [15:0] v, input logic rdy, input logic clr);
        @(posedge clk); #1;
        smp_strobe = 1'b1;
        @(posedge clk); #1;
        smp_strobe = 1'b0;
        fir_d      = v;
        out_ready  = rdy;
        ovf_clr    = clr;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; smp_strobe = 1'b0; fir_valid = 1'b1; fir_d = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        vec++; if (a_valid !== 1'b0) begin miss++; $display("FAIL rst_valid4 got=%b exp=0", a_valid); end
        vec++; if (a_data !== 16'h0) begin miss++; $display("FAIL rst_data4 got=%h exp=0000", a_data); end
        vec++; if (a_level !== 4'd0) begin miss++; $display("FAIL rst_level4 got=%0d exp=0", a_level); end
        vec++; if (b_ovf !== 1'b0) begin miss++; $display("FAIL rst_ovf1 got=%b exp=0", b_ovf); end
        vec++; if (b_level !== 4'd0) begin miss++; $display("FAIL rst_level1 got=%0d exp=0", b_level); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_decim();
        do_reset();
        fir_valid = 1'b1;
        // first strobe by hand to check the latency window
        @(posedge clk); #1;
        smp_strobe = 1'b1;
        @(posedge clk); #1;
        smp_strobe = 1'b0;
        fir_d = 16'sd1;
        vec++; if (a_valid !== 1'b0) begin miss++; $display("FAIL dec_early_valid got=%b exp=0", a_valid); end
        @(posedge clk); #1;
        vec++; if (a_valid !== 1'b1) begin miss++; $display("FAIL dec_lat_valid got=%b exp=1", a_valid); end
        vec++; if (a_data !== 16'sd1) begin miss++; $display("FAIL dec_lat_data got=%h exp=0001", a_data); end
        for (int i = 2; i <= 8; i++) strobe(16'(i), 1'b0, 1'b0);
        vec++; if (a_level !== 4'd2) begin miss++; $display("FAIL dec_level4 got=%0d exp=2", a_level); end
        vec++; if (a_data !== 16'sd1) begin miss++; $display("FAIL dec_head4 got=%h exp=0001", a_data); end
        vec++; if (b_level !== 4'd8) begin miss++; $display("FAIL dec_level1 got=%0d exp=8", b_level); end
        pop_one();
        vec++; if (a_data !== 16'sd5) begin miss++; $display("FAIL dec_second4 got=%h exp=0005", a_data); end
        vec++; if (a_level !== 4'd1) begin miss++; $display("FAIL dec_level4_pop got=%0d exp=1", a_level); end
    endtask

    task automatic test_invalid_start();
        do_reset();
        fir_valid = 1'b0;
        for (int i = 10; i <= 12; i++) strobe(16'(i), 1'b0, 1'b0);
        vec++; if (a_level !== 4'd0) begin miss++; $display("FAIL inv_level got=%0d exp=0", a_level); end
        vec++; if (b_level !== 4'd0) begin miss++; $display("FAIL inv_level1 got=%0d exp=0", b_level); end
        fir_valid = 1'b1;
        strobe(16'sd13, 1'b0, 1'b0);
        vec++; if (a_level !== 4'd1) begin miss++; $display("FAIL inv_first_level got=%0d exp=1", a_level); end
        vec++; if (a_data !== 16'sd13) begin miss++; $display("FAIL inv_first_data got=%h exp=000d", a_data); end
        // a dropout of fir_valid returns the phase to 0: next sample is kept
        fir_valid = 1'b0;
        @(posedge clk); #1;
        fir_valid = 1'b1;
        strobe(16'sd20, 1'b0, 1'b0);
        vec++; if (a_level !== 4'd2) begin miss++; $display("FAIL inv_rephase_level got=%0d exp=2", a_level); end
        pop_one();
        vec++; if (a_data !== 16'sd20) begin miss++; $display("FAIL inv_rephase_data got=%h exp=0014", a_data); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        do_reset();
        fir_valid = 1'b1;
        for (int i = 0; i < 8; i++) strobe(16'(100 + i), 1'b0, 1'b0);
        vec++; if (b_level !== 4'd8) begin miss++; $display("FAIL ovf_full_level got=%0d exp=8", b_level); end
        vec++; if (b_ovf !== 1'b0) begin miss++; $display("FAIL ovf_before got=%b exp=0", b_ovf); end
        strobe(16'sd108, 1'b0, 1'b0);
        vec++; if (b_level !== 4'd8) begin miss++; $display("FAIL ovf_drop_level got=%0d exp=8", b_level); end
        vec++; if (b_ovf !== 1'b1) begin miss++; $display("FAIL ovf_set got=%b exp=1", b_ovf); end
        vec++; if (b_data !== 16'sd100) begin miss++; $display("FAIL ovf_head got=%h exp=0064", b_data); end
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        vec++; if (b_ovf !== 1'b0) begin miss++; $display("FAIL ovf_clr got=%b exp=0", b_ovf); end
        // clear coinciding with another drop: set wins
        strobe(16'sd109, 1'b0, 1'b1);
        vec++; if (b_ovf !== 1'b1) begin miss++; $display("FAIL ovf_set_wins got=%b exp=1", b_ovf); end
        for (int i = 0; i < 8; i++) begin
            exp = 16'(100 + i);
            vec++; if (b_data !== exp) begin miss++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, b_data, exp); end
            pop_one();
        end
        vec++; if (b_valid !== 1'b0) begin miss++; $display("FAIL ovf_empty got=%b exp=0", b_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp;
        do_reset();
        fir_valid = 1'b1;
        for (int i = 1; i <= 8; i++) strobe(16'(i), 1'b0, 1'b0);
        strobe(16'sd9, 1'b1, 1'b0);
        vec++; if (b_level !== 4'd8) begin miss++; $display("FAIL fpp_level got=%0d exp=8", b_level); end
        vec++; if (b_data !== 16'sd2) begin miss++; $display("FAIL fpp_head got=%h exp=0002", b_data); end
        vec++; if (b_ovf !== 1'b0) begin miss++; $display("FAIL fpp_ovf got=%b exp=0", b_ovf); end
        for (int i = 2; i <= 9; i++) begin
            exp = 16'(i);
            vec++; if (b_data !== exp) begin miss++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, b_data, exp); end
            pop_one();
        end
    endtask

    task automatic test_signed();
        do_reset();
        fir_valid = 1'b1;
        strobe(16'h8000, 1'b0, 1'b0);
        strobe(16'hFFFF, 1'b0, 1'b0);
        strobe(16'h7FFF, 1'b0, 1'b0);
        vec++; if (b_data !== 16'h8000) begin miss++; $display("FAIL sgn_0 got=%h exp=8000", b_data); end
        pop_one();
        vec++; if (b_data !== 16'hFFFF) begin miss++; $display("FAIL sgn_1 got=%h exp=ffff", b_data); end
        pop_one();
        vec++; if (b_data !== 16'h7FFF) begin miss++; $display("FAIL sgn_2 got=%h exp=7fff", b_data); end
        pop_one();
        // push into an empty FIFO while out_ready is high: must not pop
        strobe(16'h1234, 1'b1, 1'b0);
        vec++; if (b_valid !== 1'b1) begin miss++; $display("FAIL empty_rdy_valid got=%b exp=1", b_valid); end
        vec++; if (b_data !== 16'h1234) begin miss++; $display("FAIL empty_rdy_data got=%h exp=1234", b_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fir_valid = 1'b1;
        for (int i = 1; i <= 5; i++) strobe(16'(i), 1'b0, 1'b0);
        vec++; if (b_level !== 4'd5) begin miss++; $display("FAIL mid_pre_level got=%0d exp=5", b_level); end
        // strobe, then reset during the capture cycle
        @(posedge clk); #1;
        smp_strobe = 1'b1;
        @(posedge clk); #1;
        smp_strobe = 1'b0;
        fir_d = 16'sd77;
        #2 rst = 1'b0;
        #1;
        vec++; if (b_valid !== 1'b0) begin miss++; $display("FAIL mid_valid got=%b exp=0", b_valid); end
        vec++; if (b_level !== 4'd0) begin miss++; $display("FAIL mid_level got=%0d exp=0", b_level); end
        vec++; if (b_ovf !== 1'b0) begin miss++; $display("FAIL mid_ovf got=%b exp=0", b_ovf); end
        vec++; if (b_data !== 16'h0) begin miss++; $display("FAIL mid_data got=%h exp=0000", b_data); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vec++; if (b_level !== 4'd0) begin miss++; $display("FAIL mid_inflight got=%0d exp=0", b_level); end
        strobe(16'sd50, 1'b0, 1'b0);
        vec++; if (a_level !== 4'd1) begin miss++; $display("FAIL mid_next_level4 got=%0d exp=1", a_level); end
        vec++; if (a_data !== 16'sd50) begin miss++; $display("FAIL mid_next_data4 got=%h exp=0032", a_data); end
        vec++; if (b_data !== 16'sd50) begin miss++; $display("FAIL mid_next_data1 got=%h exp=0032", b_data); end
    endtask

    initial begin
        test_reset();
        test_decim();
        test_invalid_start();
        test_overflow();
        test_full_push_pop();
        test_signed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
